// File: rtl/rescan_fifo_filler.sv
// Write-side producer for the dual-clock rescan FIFO (wclk domain).
// Walks a lines x words frame, requests bursts only when the FIFO can take the
// whole burst, and writes returned words into the FIFO in order.
module rescan_fifo_filler #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned BURST  = 8,
  parameter int unsigned AW     = 32,
  parameter int unsigned WBYTES = 16,
  localparam int unsigned CW    = $clog2(DEPTH),
  localparam int unsigned LW    = $clog2(BURST) + 1
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             frame_start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW-1:0]    line_stride,
  input  logic [15:0]      words_line,
  input  logic [15:0]      lines_frame,
  input  logic [CW-1:0]    fifo_cnt,
  output logic             fifo_wr,
  output logic [WIDTH-1:0] fifo_din,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [AW-1:0]    req_addr,
  output logic [LW-1:0]    req_len,
  input  logic             rsp_valid,
  input  logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             done,
  output logic             ovf_err
);

  typedef enum logic [2:0] {StIdle, StCheck, StReq, StWait, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    stride_q, stride_d;
  logic [15:0]      words_q, words_d;
  logic [15:0]      lines_q, lines_d;
  logic [AW-1:0]    line_addr_q, line_addr_d;
  logic [AW-1:0]    cur_addr_q, cur_addr_d;
  logic [15:0]      line_idx_q, line_idx_d;
  logic [15:0]      word_idx_q, word_idx_d;
  logic [LW-1:0]    outst_q, outst_d;
  logic             pend_q, pend_d;
  logic             fifo_wr_q, fifo_wr_d;
  logic [WIDTH-1:0] fifo_din_q, fifo_din_d;
  logic             req_valid_q, req_valid_d;
  logic [AW-1:0]    req_addr_q, req_addr_d;
  logic [LW-1:0]    req_len_q, req_len_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [16:0]      rem;
  logic [LW-1:0]    len_c;
  logic             room;
  logic             load;
  logic [15:0]      word_n;
  logic [15:0]      line_n;
  logic [AW-1:0]    line_addr_n;

  // Next-state logic for the frame walker, response path and outputs.
  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    words_d     = words_q;
    lines_d     = lines_q;
    line_addr_d = line_addr_q;
    cur_addr_d  = cur_addr_q;
    line_idx_d  = line_idx_q;
    word_idx_d  = word_idx_q;
    outst_d     = outst_q;
    pend_d      = pend_q;
    fifo_wr_d   = 1'b0;
    fifo_din_d  = fifo_din_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_len_d   = req_len_q;
    ovf_d       = ovf_q;
    done_d      = (state_q == StDone);
    load        = 1'b0;

    // Burst length never crosses the end of the current line.
    rem   = {1'b0, words_q} - {1'b0, word_idx_q};
    len_c = (rem > 17'(BURST)) ? LW'(BURST) : rem[LW-1:0];
    // fifo_cnt only lags on the read side, so this test can only under-estimate room.
    room  = (32'(fifo_cnt) + 32'(len_c)) <= 32'(DEPTH - 1);

    word_n      = word_idx_q + 16'(req_len_q);
    line_n      = line_idx_q + 16'd1;
    line_addr_n = line_addr_q + stride_q;

    // Responses are only legal while a burst is outstanding; others are dropped.
    if (rsp_valid) begin
      if (state_q == StWait && outst_q != '0) begin
        fifo_wr_d  = 1'b1;
        fifo_din_d = rsp_data;
        outst_d    = outst_q - LW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (frame_start && state_q != StIdle) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (frame_start || pend_q) begin
          load   = 1'b1;
          pend_d = 1'b0;
        end
      end
      StCheck: begin
        if (room) begin
          req_valid_d = 1'b1;
          req_addr_d  = cur_addr_q;
          req_len_d   = len_c;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          outst_d     = req_len_q;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (rsp_valid && outst_q == LW'(1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pend_q || frame_start) begin
          // Restart replaces the current frame; its done pulse is never emitted.
          load   = 1'b1;
          pend_d = 1'b0;
        end else if (word_n == words_q) begin
          word_idx_d  = '0;
          line_idx_d  = line_n;
          line_addr_d = line_addr_n;
          cur_addr_d  = line_addr_n;
          state_d     = (line_n == lines_q) ? StDone : StCheck;
        end else begin
          word_idx_d = word_n;
          cur_addr_d = cur_addr_q + AW'(req_len_q) * AW'(WBYTES);
          state_d    = StCheck;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (load) begin
      stride_d    = line_stride;
      words_d     = words_line;
      lines_d     = lines_frame;
      line_addr_d = base_addr;
      cur_addr_d  = base_addr;
      line_idx_d  = '0;
      word_idx_d  = '0;
      state_d     = (words_line == '0 || lines_frame == '0) ? StDone : StCheck;
    end

    busy_d = (state_d != StIdle) && (state_d != StDone);
  end

  // State and registered outputs.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q     <= StIdle;
      stride_q    <= '0;
      words_q     <= '0;
      lines_q     <= '0;
      line_addr_q <= '0;
      cur_addr_q  <= '0;
      line_idx_q  <= '0;
      word_idx_q  <= '0;
      outst_q     <= '0;
      pend_q      <= 1'b0;
      fifo_wr_q   <= 1'b0;
      fifo_din_q  <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stride_q    <= stride_d;
      words_q     <= words_d;
      lines_q     <= lines_d;
      line_addr_q <= line_addr_d;
      cur_addr_q  <= cur_addr_d;
      line_idx_q  <= line_idx_d;
      word_idx_q  <= word_idx_d;
      outst_q     <= outst_d;
      pend_q      <= pend_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_din_q  <= fifo_din_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_len_q   <= req_len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign fifo_wr   = fifo_wr_q;
  assign fifo_din  = fifo_din_q;
  assign req_valid = req_valid_q;
  assign req_addr  = req_addr_q;
  assign req_len   = req_len_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_rescan_fifo_filler.sv
// Self-checking bench for rescan_fifo_filler: a bus responder, a monitor and a
// frame-walk reference model built from plain nested loops.
module tb_rescan_fifo_filler;
  localparam int unsigned WIDTH  = 128;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned BURST  = 8;
  localparam int unsigned AW     = 32;
  localparam int unsigned WBYTES = 16;

  logic             wclk = 1'b0;
  logic             wrst;
  logic             frame_start;
  logic [AW-1:0]    base_addr;
  logic [AW-1:0]    line_stride;
  logic [15:0]      words_line;
  logic [15:0]      lines_frame;
  logic [7:0]       fifo_cnt;
  logic             fifo_wr;
  logic [WIDTH-1:0] fifo_din;
  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_addr;
  logic [3:0]       req_len;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;
  logic             done;
  logic             ovf_err;

  rescan_fifo_filler #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .BURST (BURST),
    .AW    (AW),
    .WBYTES(WBYTES)
  ) dut (
    .wclk       (wclk),
    .wrst       (wrst),
    .frame_start(frame_start),
    .base_addr  (base_addr),
    .line_stride(line_stride),
    .words_line (words_line),
    .lines_frame(lines_frame),
    .fifo_cnt   (fifo_cnt),
    .fifo_wr    (fifo_wr),
    .fifo_din   (fifo_din),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .done       (done),
    .ovf_err    (ovf_err)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_fail   = 0;

  // 0: random ready, 1: held low, 2: held high
  int ready_mode = 2;
  int stray_req  = 0;
  int stray_done = 0;
  int done_cnt   = 0;

  logic [AW-1:0]    rsp_q[$];
  logic [AW-1:0]    obs_addr[$];
  int               obs_len[$];
  logic [WIDTH-1:0] obs_wr[$];

  logic [AW-1:0]    exp_addr[$];
  int               exp_len[$];
  logic [WIDTH-1:0] exp_wr[$];

  function automatic logic [WIDTH-1:0] data_of(input logic [AW-1:0] a);
    return {~a, a ^ 32'h5a5a_5a5a, a + 32'h0000_1234, a};
  endfunction

  // Monitor: sample mid-cycle, when DUT outputs and bench inputs are both settled.
  initial begin
    forever begin
      @(negedge wclk);
      if (!wrst && req_valid && req_ready) begin
        obs_addr.push_back(req_addr);
        obs_len.push_back(int'(req_len));
        for (int i = 0; i < int'(req_len); i++) rsp_q.push_back(req_addr + 32'(i * WBYTES));
      end
      if (fifo_wr) obs_wr.push_back(fifo_din);
      if (done) done_cnt++;
    end
  end

  // Bus responder and req_ready driver.
  initial begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    req_ready = 1'b0;
    forever begin
      @(posedge wclk);
      #1;
      case (ready_mode)
        0:       req_ready = 1'($urandom_range(0, 1));
        1:       req_ready = 1'b0;
        default: req_ready = 1'b1;
      endcase
      if (stray_req != stray_done) begin
        rsp_valid = 1'b1;
        rsp_data  = {4{32'hdead_beef}};
        stray_done++;
      end else if (rsp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        rsp_valid = 1'b1;
        rsp_data  = data_of(rsp_q.pop_front());
      end else begin
        rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wclk);
      #1;
    end
  endtask

  task automatic exp_clear();
    exp_addr.delete();
    exp_len.delete();
    exp_wr.delete();
  endtask

  task automatic exp_burst(input logic [AW-1:0] a, input int len);
    exp_addr.push_back(a);
    exp_len.push_back(len);
    for (int i = 0; i < len; i++) exp_wr.push_back(data_of(a + 32'(i * WBYTES)));
  endtask

  // Reference walk: line by line, chunks of at most BURST words, modulo-2^32 addresses.
  task automatic exp_frame(input logic [AW-1:0] b, input logic [AW-1:0] s,
                           input int words, input int lines);
    for (int l = 0; l < lines; l++) begin
      for (int w = 0; w < words; w += BURST) begin
        exp_burst(b + 32'(l) * s + 32'(w * WBYTES), (words - w > BURST) ? BURST : words - w);
      end
    end
  endtask

  task automatic start_frame(input logic [AW-1:0] b, input logic [AW-1:0] s,
                             input int words, input int lines);
    base_addr   = b;
    line_stride = s;
    words_line  = 16'(words);
    lines_frame = 16'(lines);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int c = 0;
    while (done_cnt < target && c < budget) begin
      tick(1);
      c++;
    end
    n_checks++;
    if (done_cnt < target) begin
      n_fail++;
      $display("FAIL %s done_wait: got %0d done pulses, required %0d", name, done_cnt, target);
    end
  endtask

  task automatic check_stream(input string name, input int r0, input int w0, input int d0);
    n_checks++;
    if (obs_addr.size() - r0 !== exp_addr.size()) begin
      n_fail++;
      $display("FAIL %s req_count: got %0d required %0d", name, obs_addr.size() - r0,
               exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (r0 + i < obs_addr.size()) begin
        n_checks++;
        if (obs_addr[r0+i] !== exp_addr[i] || obs_len[r0+i] !== exp_len[i]) begin
          n_fail++;
          $display("FAIL %s req%0d: got (%h,%0d) required (%h,%0d)", name, i, obs_addr[r0+i],
                   obs_len[r0+i], exp_addr[i], exp_len[i]);
        end
      end
    end
    n_checks++;
    if (obs_wr.size() - w0 !== exp_wr.size()) begin
      n_fail++;
      $display("FAIL %s wr_count: got %0d required %0d", name, obs_wr.size() - w0, exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size(); i++) begin
      if (w0 + i < obs_wr.size()) begin
        n_checks++;
        if (obs_wr[w0+i] !== exp_wr[i]) begin
          n_fail++;
          $display("FAIL %s wr%0d: got %h required %h", name, i, obs_wr[w0+i], exp_wr[i]);
        end
      end
    end
    n_checks++;
    if (done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt - d0);
    end
    n_checks++;
    if (busy !== 1'b0 || ovf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_flags: got busy=%b ovf=%b required 0 0", name, busy, ovf_err);
    end
  endtask

  task automatic run_frame(input string name, input logic [AW-1:0] b, input logic [AW-1:0] s,
                           input int words, input int lines);
    int r0 = obs_addr.size();
    int w0 = obs_wr.size();
    int d0 = done_cnt;
    exp_clear();
    exp_frame(b, s, words, lines);
    start_frame(b, s, words, lines);
    wait_done(name, d0 + 1, 4000);
    tick(4);
    check_stream(name, r0, w0, d0);
  endtask

  task automatic test_reset();
    wrst = 1'b1;
    tick(3);
    n_checks++;
    if ({fifo_wr, req_valid, busy, done, ovf_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000", {fifo_wr, req_valid, busy, done, ovf_err});
    end
    n_checks++;
    if (req_addr !== '0 || req_len !== '0) begin
      n_fail++;
      $display("FAIL reset_req: got addr=%h len=%0d required 0 0", req_addr, req_len);
    end
    n_checks++;
    if (fifo_din !== '0) begin
      n_fail++;
      $display("FAIL reset_din: got %h required 0", fifo_din);
    end
    wrst = 1'b0;
    tick(2);
    n_checks++;
    if ({req_valid, busy, done} !== 3'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b required 000", {req_valid, busy, done});
    end
  endtask

  task automatic test_basic_frame();
    logic [AW-1:0] ref_a[6];
    int            ref_l[6];
    int            r0 = obs_addr.size();
    ref_a = '{32'h1000, 32'h1080, 32'h1100, 32'h1400, 32'h1480, 32'h1500};
    ref_l = '{8, 8, 4, 8, 8, 4};
    ready_mode = 2;
    fifo_cnt   = 8'd0;
    run_frame("basic", 32'h1000, 32'h400, 20, 2);
    for (int i = 0; i < 6; i++) begin
      if (r0 + i < obs_addr.size()) begin
        n_checks++;
        if (obs_addr[r0+i] !== ref_a[i] || obs_len[r0+i] !== ref_l[i]) begin
          n_fail++;
          $display("FAIL basic_table%0d: got (%h,%0d) required (%h,%0d)", i, obs_addr[r0+i],
                   obs_len[r0+i], ref_a[i], ref_l[i]);
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    int r0 = obs_addr.size();
    int w0 = obs_wr.size();
    int d0 = done_cnt;
    logic seen = 1'b0;
    logic rose = 1'b0;
    ready_mode = 1;
    fifo_cnt   = 8'd250;
    exp_clear();
    exp_frame(32'h2000, 32'h100, 8, 1);
    start_frame(32'h2000, 32'h100, 8, 1);
    for (int i = 0; i < 10; i++) begin
      if (req_valid) seen = 1'b1;
      tick(1);
    end
    fifo_cnt = 8'd248;  // 248 + 8 is one over capacity
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (req_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL full_hold: got req_valid=1 required 0 while FIFO lacks room");
    end
    fifo_cnt = 8'd247;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      if (req_valid) rose = 1'b1;
    end
    n_checks++;
    if (rose !== 1'b1) begin
      n_fail++;
      $display("FAIL full_release: got req_valid=0 required 1 within 2 clks");
    end
    fifo_cnt   = 8'd0;
    ready_mode = 2;
    wait_done("fifo_full", d0 + 1, 2000);
    tick(4);
    check_stream("fifo_full", r0, w0, d0);
  endtask

  task automatic test_backpressure();
    int r0 = obs_addr.size();
    int w0 = obs_wr.size();
    int d0 = done_cnt;
    int c = 0;
    logic [AW-1:0] a0;
    logic [3:0]    l0;
    logic stable = 1'b1;
    ready_mode = 1;
    exp_clear();
    exp_frame(32'h3000, 32'h40, 8, 1);
    start_frame(32'h3000, 32'h40, 8, 1);
    while (!req_valid && c < 20) begin
      tick(1);
      c++;
    end
    a0 = req_addr;
    l0 = req_len;
    n_checks++;
    if (req_valid !== 1'b1 || a0 !== 32'h3000 || l0 !== 4'd8) begin
      n_fail++;
      $display("FAIL bp_first: got v=%b addr=%h len=%0d required 1 3000 8", req_valid, a0, l0);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (req_valid !== 1'b1 || req_addr !== a0 || req_len !== l0) stable = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stable: got unstable request required stable for 5 clks");
    end
    ready_mode = 2;
    wait_done("backpressure", d0 + 1, 2000);
    tick(4);
    check_stream("backpressure", r0, w0, d0);
  endtask

  task automatic test_restart();
    int r0 = obs_addr.size();
    int w0 = obs_wr.size();
    int d0 = done_cnt;
    int c = 0;
    ready_mode = 2;
    exp_clear();
    exp_burst(32'h1000, 8);
    exp_frame(32'h8000, 32'h200, 12, 1);
    start_frame(32'h1000, 32'h400, 20, 2);
    while (obs_addr.size() <= r0 && c < 50) begin
      tick(1);
      c++;
    end
    start_frame(32'h8000, 32'h200, 12, 1);
    wait_done("restart", d0 + 1, 2000);
    tick(10);
    check_stream("restart", r0, w0, d0);
  endtask

  task automatic test_ovf();
    int w0 = obs_wr.size();
    stray_req++;
    tick(3);
    n_checks++;
    if (ovf_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b required 1", ovf_err);
    end
    n_checks++;
    if (obs_wr.size() !== w0) begin
      n_fail++;
      $display("FAIL ovf_nowrite: got %0d writes required 0", obs_wr.size() - w0);
    end
    tick(5);
    n_checks++;
    if (ovf_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b required 1", ovf_err);
    end
    wrst = 1'b1;
    tick(1);
    wrst = 1'b0;
    n_checks++;
    if (ovf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b required 0", ovf_err);
    end
  endtask

  task automatic test_zero_frame(input string name, input int words, input int lines);
    int r0 = obs_addr.size();
    int d0 = done_cnt;
    logic [2:0] seq;
    logic       rv = 1'b0;
    base_addr   = 32'h4000;
    line_stride = 32'h100;
    words_line  = 16'(words);
    lines_frame = 16'(lines);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    seq[0] = done;
    rv |= req_valid;
    tick(1);
    seq[1] = done;
    rv |= req_valid;
    tick(1);
    seq[2] = done;
    rv |= req_valid;
    n_checks++;
    if (seq !== 3'b010) begin
      n_fail++;
      $display("FAIL %s done_timing: got %b required 010", name, seq);
    end
    tick(5);
    n_checks++;
    if (rv !== 1'b0 || obs_addr.size() !== r0 || done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL %s no_req: got rv=%b reqs=%0d dones=%0d required 0 0 1", name, rv,
               obs_addr.size() - r0, done_cnt - d0);
    end
  endtask

  task automatic test_random_frames();
    logic [AW-1:0] b;
    logic [AW-1:0] s;
    ready_mode = 0;
    for (int k = 0; k < 6; k++) begin
      b = (k == 0) ? 32'hffff_ff80 : ($urandom & 32'hffff_fff0);
      s = 32'($urandom_range(0, 256)) * 32'd16;
      fifo_cnt = 8'($urandom_range(0, 200));
      run_frame($sformatf("rand%0d", k), b, s, $urandom_range(1, 40), $urandom_range(1, 3));
    end
    fifo_cnt   = 8'd0;
    ready_mode = 2;
  endtask

  initial begin
    wrst        = 1'b1;
    frame_start = 1'b0;
    base_addr   = '0;
    line_stride = '0;
    words_line  = '0;
    lines_frame = '0;
    fifo_cnt    = '0;
    test_reset();
    test_basic_frame();
    test_fifo_full();
    test_backpressure();
    test_restart();
    test_ovf();
    test_zero_frame("zero_lines", 5, 0);
    test_zero_frame("zero_words", 0, 3);
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
